// File: rtl/spi_master_tx_if.sv
// Word handshake and SPI pin bundle of the display-command SPI master.
// master = word producer / pin observer, slave = spi_master_tx itself.
interface spi_master_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic                  o_spi_clk;
    logic                  o_spi_cs;
    logic                  o_spi_mosi;
    logic                  o_busy;
    logic                  o_done_pls;

    modport master (
        output i_tx_data,
        output i_tx_valid,
        input  o_tx_ready,
        input  o_spi_clk,
        input  o_spi_cs,
        input  o_spi_mosi,
        input  o_busy,
        input  o_done_pls
    );

    modport slave (
        input  i_tx_data,
        input  i_tx_valid,
        output o_tx_ready,
        output o_spi_clk,
        output o_spi_cs,
        output o_spi_mosi,
        output o_busy,
        output o_done_pls
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: one DATA_WIDTH word per handshake, shifted
// MSB-first on MOSI inside an active-low CS frame with setup/hold/idle guard times.
module spi_master_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int CLK_DIV    = 2,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_IDLE    = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    spi_master_tx_if.slave bus
);

    localparam int SHIFT_LEN = 2 * CLK_DIV;
    localparam int MAX_A     = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_B     = (CS_IDLE > SHIFT_LEN) ? CS_IDLE : SHIFT_LEN;
    localparam int MAX_CNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);
    localparam int BIT_W     = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(SHIFT_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;

    // State register: every registered output is loaded from the value the
    // output decoder derives for the state being entered, so pins line up with state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: cnt_q counts cycles inside the current state (or
    // inside the current bit while shifting); bit_q counts transmitted bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (bus.i_tx_valid) begin
                    state_d = SETUP;
                    shreg_d = bus.i_tx_data;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state: the last bit is never shifted
    // out of the register, so MOSI keeps the LSB through HOLD.
    always_comb begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            SETUP, HOLD: begin
                cs_d   = 1'b0;
                mosi_d = shreg_d[DATA_WIDTH-1];
            end
            SHIFT: begin
                cs_d   = 1'b0;
                sclk_d = (cnt_d > HALF_LAST);
                mosi_d = shreg_d[DATA_WIDTH-1];
            end
            GAP: begin
                done_d = (state_q == HOLD);
            end
            default: begin
                cs_d = 1'b1;
            end
        endcase
    end

    assign bus.o_tx_ready = (state_q == IDLE);
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_spi_cs   = cs_q;
    assign bus.o_spi_clk  = sclk_q;
    assign bus.o_spi_mosi = mosi_q;
    assign bus.o_done_pls = done_q;

endmodule
